// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and parameter defaults for multicycle_sequencer
package seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM_WAIT  = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [5:0] HALT_OPCODE_DEF = 6'b100100;
  localparam int         CNT_W_DEF       = 32;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - counter with sync clear and enable that holds at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle control FSM gating datapath commits, mem wait/timeout, halt, perf counters
// Optional single-step debug enabled by defining STEP_DEBUG_EN.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int                  OPCODE_W     = 6,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE  = HALT_OPCODE_DEF,
  parameter int                  CNT_W        = CNT_W_DEF,
  parameter int                  MEM_WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                is_mem_op,
  input  logic                mem_ready,
  input  logic                resume,
  input  logic                step_en,
  input  logic                step_req,
  input  logic                upd_pc_in,
  input  logic                wr_reg_in,
  input  logic                wr_mem_in,
  output logic                upd_pc_gated,
  output logic                wr_reg_gated,
  output logic                wr_mem_gated,
  output logic                mem_req,
  output logic [2:0]          state,
  output logic                halted,
  output logic                timeout_err,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    instr_count
);

  localparam int                WAIT_W    = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_t            state_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_req_q;
  logic              halted_q;
  logic              timeout_q;
  logic              is_halt_op;
  logic              wb_to_halt;
  logic              halt_leave;

  assign is_halt_op = (opcode == HALT_OPCODE);

`ifdef STEP_DEBUG_EN
  assign wb_to_halt = step_en;
  assign halt_leave = !timeout_q && (resume || step_req);
`else
  logic unused_step;
  assign unused_step = &{1'b0, step_en, step_req};
  assign wb_to_halt  = 1'b0;
  assign halt_leave  = !timeout_q && resume;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      mem_req_q <= 1'b0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      mem_req_q <= 1'b0;
      halted_q  <= 1'b0;
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: state_q <= S_EXECUTE;
        S_EXECUTE: begin
          if (is_halt_op) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else if (is_mem_op) begin
            state_q   <= S_MEM_WAIT;
            mem_req_q <= 1'b1;
          end else begin
            state_q <= S_WRITEBACK;
          end
        end
        // A ready arriving on the last allowed cycle still completes the access.
        S_MEM_WAIT: begin
          if (mem_ready) begin
            state_q <= S_WRITEBACK;
          end else if (wait_cnt == WAIT_LAST) begin
            state_q   <= S_HALT;
            halted_q  <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          if (wb_to_halt) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_HALT: begin
          if (halt_leave) state_q <= S_FETCH;
          else            halted_q <= 1'b1;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    upd_pc_gated = 1'b0;
    wr_reg_gated = 1'b0;
    wr_mem_gated = 1'b0;
    if (state_q == S_WRITEBACK) begin
      upd_pc_gated = upd_pc_in;
      wr_reg_gated = wr_reg_in;
      wr_mem_gated = wr_mem_in;
    end else if (state_q == S_EXECUTE && is_halt_op) begin
      upd_pc_gated = upd_pc_in;
    end
  end

  assign state       = state_q;
  assign mem_req     = mem_req_q;
  assign halted      = halted_q;
  assign timeout_err = timeout_q;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .en    (state_q != S_HALT),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .en    ((state_q == S_WRITEBACK) || (state_q == S_EXECUTE && is_halt_op)),
    .count (instr_count)
  );

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (state_q != S_MEM_WAIT),
    .en    (state_q == S_MEM_WAIT),
    .count (wait_cnt)
  );

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - scoreboard bench for multicycle_sequencer
module tb_multicycle_sequencer;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        is_mem_op, mem_ready, resume, step_en, step_req;
  logic        upd_pc_in, wr_reg_in, wr_mem_in;
  logic        upd_pc_gated, wr_reg_gated, wr_mem_gated;
  logic        mem_req, halted, timeout_err;
  logic [2:0]  state;
  logic [31:0] cycle_count, instr_count;

  typedef struct {
    logic [2:0]  st;
    logic        u, r, w;
    logic [31:0] ic;
  } ev_t;

  ev_t sb[$];
  int  n_vec = 0;
  int  n_bad = 0;

  multicycle_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .is_mem_op    (is_mem_op),
    .mem_ready    (mem_ready),
    .resume       (resume),
    .step_en      (step_en),
    .step_req     (step_req),
    .upd_pc_in    (upd_pc_in),
    .wr_reg_in    (wr_reg_in),
    .wr_mem_in    (wr_mem_in),
    .upd_pc_gated (upd_pc_gated),
    .wr_reg_gated (wr_reg_gated),
    .wr_mem_gated (wr_mem_gated),
    .mem_req      (mem_req),
    .state        (state),
    .halted       (halted),
    .timeout_err  (timeout_err),
    .cycle_count  (cycle_count),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic push_ev(input logic [2:0] st, input logic u, r, w, input logic [31:0] ic);
    ev_t e;
    e.st = st; e.u = u; e.r = r; e.w = w; e.ic = ic;
    sb.push_back(e);
  endtask

  // Monitor: every cycle with a commit must match the oldest queued expectation.
  always @(negedge clk) begin
    if (upd_pc_gated || wr_reg_gated || wr_mem_gated) begin
      if (sb.size() == 0) begin
        check("unexpected_commit", {state, upd_pc_gated, wr_reg_gated, wr_mem_gated}, 64'h0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("commit", {state, upd_pc_gated, wr_reg_gated, wr_mem_gated, instr_count},
              {e.st, e.u, e.r, e.w, e.ic});
      end
    end
  end

  task automatic expect_state(input string nm, input logic [2:0] s);
    check(nm, state, s);
    @(negedge clk);
  endtask

  task automatic run_mem(input int n, input bit rdy_last);
    expect_state("mem.fetch", 3'd0);
    expect_state("mem.decode", 3'd1);
    expect_state("mem.execute", 3'd2);
    for (int i = 0; i < n; i++) begin
      if (rdy_last && i == n - 1) mem_ready = 1'b1;
      check("mem.req", {state, mem_req}, {3'd3, 1'b1});
      @(negedge clk);
    end
    mem_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    check("rst.async", {state, mem_req, halted, timeout_err, cycle_count, instr_count}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; opcode = 6'd0; is_mem_op = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    step_en = 1'b0; step_req = 1'b0; upd_pc_in = 1'b1; wr_reg_in = 1'b1; wr_mem_in = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_state", {state, upd_pc_gated, wr_reg_gated, wr_mem_gated, mem_req, halted,
                          timeout_err, cycle_count, instr_count}, 64'h0);
    reset = 1'b1;
    wr_mem_in = 1'b0;

    // ADD: 0,1,2,4 then back to FETCH
    push_ev(3'd4, 1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [2:0] s;
      s = (i == 3) ? 3'd4 : 3'(i);
      check("add.wr_reg_gate", {state, wr_reg_gated}, {s, s == 3'd4});
      @(negedge clk);
    end
    check("add.done", {state, instr_count, cycle_count}, {3'd0, 32'd1, 32'd4});

    // LW: ready on the third MEM_WAIT cycle
    opcode = 6'h23; is_mem_op = 1'b1;
    push_ev(3'd4, 1'b1, 1'b1, 1'b0, 32'd1);
    run_mem(3, 1'b1);
    expect_state("lw.wb", 3'd4);
    check("lw.done", {state, mem_req, instr_count, cycle_count}, {3'd0, 1'b0, 32'd2, 32'd11});

    // HALT opcode: PC update in EXECUTE only, counter frozen while halted
    opcode = 6'b100100; is_mem_op = 1'b0;
    push_ev(3'd2, 1'b1, 1'b0, 1'b0, 32'd2);
    expect_state("hlt.fetch", 3'd0);
    expect_state("hlt.decode", 3'd1);
    expect_state("hlt.execute", 3'd2);
    check("hlt.enter", {state, halted, instr_count, cycle_count}, {3'd5, 1'b1, 32'd3, 32'd14});
    repeat (10) @(negedge clk);
    check("hlt.frozen", {state, halted, cycle_count}, {3'd5, 1'b1, 32'd14});
    opcode = 6'd0; resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("hlt.resume", {state, halted, cycle_count}, {3'd0, 1'b0, 32'd14});

    // SW: ready held high, single MEM_WAIT cycle
    is_mem_op = 1'b1; wr_reg_in = 1'b0; wr_mem_in = 1'b1; mem_ready = 1'b1;
    push_ev(3'd4, 1'b1, 1'b0, 1'b1, 32'd3);
    run_mem(1, 1'b1);
    expect_state("sw.wb", 3'd4);
    check("sw.done", {state, instr_count}, {3'd0, 32'd4});

    // LW: ready arrives on the timeout cycle and wins
    wr_reg_in = 1'b1; wr_mem_in = 1'b0;
    push_ev(3'd4, 1'b1, 1'b1, 1'b0, 32'd4);
    run_mem(15, 1'b1);
    expect_state("edge.wb", 3'd4);
    check("edge.done", {state, timeout_err, instr_count}, {3'd0, 1'b0, 32'd5});

    // Reset in the middle of MEM_WAIT, then a clean ADD
    expect_state("mrst.fetch", 3'd0);
    expect_state("mrst.decode", 3'd1);
    expect_state("mrst.execute", 3'd2);
    check("mrst.wait", {state, mem_req}, {3'd3, 1'b1});
    pulse_reset();
    is_mem_op = 1'b0;
    push_ev(3'd4, 1'b1, 1'b1, 1'b0, 32'd0);
    expect_state("add2.fetch", 3'd0);
    expect_state("add2.decode", 3'd1);
    expect_state("add2.execute", 3'd2);
    expect_state("add2.wb", 3'd4);
    check("add2.done", {state, instr_count, cycle_count}, {3'd0, 32'd1, 32'd4});

    // LW with no ready: timeout after MEM_WAIT_MAX cycles, resume ignored
    is_mem_op = 1'b1;
    run_mem(15, 1'b0);
    check("tmo.halt", {state, halted, timeout_err, mem_req, instr_count},
          {3'd5, 1'b1, 1'b1, 1'b0, 32'd1});
    resume = 1'b1;
    repeat (3) @(negedge clk);
    check("tmo.resume_ignored", {state, timeout_err}, {3'd5, 1'b1});
    resume = 1'b0;
    pulse_reset();
    check("tmo.cleared", {state, timeout_err}, {3'd0, 1'b0});

`ifdef STEP_DEBUG_EN
    // Single step: each ADD halts after writeback, a step_req pulse retires one more
    is_mem_op = 1'b0; step_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_ev(3'd4, 1'b1, 1'b1, 1'b0, 32'(k));
      expect_state("step.fetch", 3'd0);
      expect_state("step.decode", 3'd1);
      expect_state("step.execute", 3'd2);
      expect_state("step.wb", 3'd4);
      check("step.halt", {state, halted, instr_count}, {3'd5, 1'b1, 32'(k + 1)});
      repeat (2) @(negedge clk);
      check("step.hold", {state, instr_count}, {3'd5, 32'(k + 1)});
      step_req = 1'b1;
      @(negedge clk);
      step_req = 1'b0;
    end
    step_en = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("sb_drain", sb.size(), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
